alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 67 ++++++
 tb/tb_alu_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one registered-output ALU via round-robin grant
module alu_arbiter #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [1:0]   req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [1:0]   req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_result,
  output logic [2:0]   rsp_cc
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t       r_state;
  logic         r_last;
  logic         r_id;
  logic [W-1:0] r_result;
  logic [2:0]   r_cc;
  logic         w_can, w_gnt, w_acc, w_of;
  logic [2:0]   w_op;
  logic [W-1:0] w_a, w_b, w_res;
  assign w_can = (r_state == EMPTY) || rsp_ready;
  // on a tie the requester not served last wins; otherwise whichever is valid
  assign w_gnt = (req0_valid && req1_valid) ? ~r_last : req1_valid;
  assign w_acc = !rst && w_can && (req0_valid || req1_valid);
  assign req0_ready = w_acc && !w_gnt;
  assign req1_ready = w_acc && w_gnt;
  assign w_op = {1'b0, w_gnt ? req1_op : req0_op};
  assign w_a  = w_gnt ? req1_a : req0_a;
  assign w_b  = w_gnt ? req1_b : req0_b;
  assign w_res = (w_op == 3'd0) ? w_a + w_b :
                 (w_op == 3'd1) ? w_a - w_b :
                 (w_op == 3'd2) ? w_a & w_b : w_a ^ w_b;
  assign w_of = (w_op == 3'd0) ? (w_a[W-1] == w_b[W-1]) && (w_res[W-1] != w_a[W-1]) :
                (w_op == 3'd1) ? (w_a[W-1] != w_b[W-1]) && (w_res[W-1] != w_a[W-1]) : 1'b0;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= EMPTY;
      r_last   <= 1'b1;
      r_id     <= 1'b0;
      r_result <= '0;
      r_cc     <= 3'b000;
    end else if (w_acc) begin
      r_state  <= FULL;
      r_last   <= w_gnt;
      r_id     <= w_gnt;
      r_result <= w_res;
      r_cc     <= {w_res == '0, w_res[W-1], w_of};
    end else if (rsp_ready) begin
      r_state  <= EMPTY;
    end
  end
  assign rsp_valid  = (r_state == FULL);
  assign rsp_id     = r_id;
  assign rsp_result = r_result;
  assign rsp_cc     = r_cc;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vector table plus hand-written arbitration/stall/reset sequences
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
  logic        req0_ready, req1_ready, rsp_valid, rsp_id;
  logic [1:0]  req0_op = '0, req1_op = '0;
  logic [63:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [63:0] rsp_result;
  logic [2:0]  rsp_cc;
  int errors = 0, checks = 0;

  alu_arbiter #(.W(64)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_cc(rsp_cc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic [1:0]  op;
    logic [63:0] a, b, res;
    logic [2:0]  cc;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    vecs[0] = '{0, 2'd0, 64'd3, 64'd5, 64'd8, 3'b000};
    vecs[1] = '{0, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 3'b011};
    vecs[2] = '{0, 2'd1, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 3'b001};
    vecs[3] = '{0, 2'd2, 64'hFFFF_0000_0000_0000, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0000, 3'b010};
    vecs[4] = '{0, 2'd1, 64'd7, 64'd7, 64'd0, 3'b100};
    vecs[5] = '{1, 2'd3, 64'hF, 64'hF0, 64'hFF, 3'b000};
    vecs[6] = '{1, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 3'b100};
    vecs[7] = '{1, 2'd1, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 3'b010};
    vecs[8] = '{1, 2'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 3'b101};
    vecs[9] = '{0, 2'd3, 64'hAA, 64'hAA, 64'd0, 3'b100};

    // reset state, with both requesters asserting valid
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    step();
    check("rst_rdy0", 64'(req0_ready), 64'd0);
    check("rst_rdy1", 64'(req1_ready), 64'd0);
    check("rst_valid", 64'(rsp_valid), 64'd0);
    check("rst_id", 64'(rsp_id), 64'd0);
    check("rst_result", rsp_result, 64'd0);
    check("rst_cc", 64'(rsp_cc), 64'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      req0_valid = !vecs[i].id; req1_valid = vecs[i].id;
      req0_op = vecs[i].op; req0_a = vecs[i].a; req0_b = vecs[i].b;
      req1_op = vecs[i].op; req1_a = vecs[i].a; req1_b = vecs[i].b;
      #1;
      check($sformatf("v%0d_rdy0", i), 64'(req0_ready), 64'(!vecs[i].id));
      check($sformatf("v%0d_rdy1", i), 64'(req1_ready), 64'(vecs[i].id));
      step();
      req0_valid = 1'b0; req1_valid = 1'b0;
      check($sformatf("v%0d_valid", i), 64'(rsp_valid), 64'd1);
      check($sformatf("v%0d_id", i), 64'(rsp_id), 64'(vecs[i].id));
      check($sformatf("v%0d_result", i), rsp_result, vecs[i].res);
      check($sformatf("v%0d_cc", i), 64'(rsp_cc), 64'(vecs[i].cc));
    end
    step();
    check("drain_valid", 64'(rsp_valid), 64'd0);

    // alternating grants under continuous contention
    do_reset();
    req0_op = 2'd1; req0_a = 64'd7; req0_b = 64'd7;
    req1_op = 2'd3; req1_a = 64'hF; req1_b = 64'hF0;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("alt%0d_rdy0", i), 64'(req0_ready), 64'(i % 2 == 0));
      check($sformatf("alt%0d_rdy1", i), 64'(req1_ready), 64'(i % 2 == 1));
      step();
      check($sformatf("alt%0d_id", i), 64'(rsp_id), 64'(i % 2));
      check($sformatf("alt%0d_result", i), rsp_result, (i % 2 == 0) ? 64'd0 : 64'hFF);
      check($sformatf("alt%0d_cc", i), 64'(rsp_cc), (i % 2 == 0) ? 64'd4 : 64'd0);
    end

    // backpressure: first accept, then four stalled cycles
    do_reset();
    rsp_ready = 1'b0;
    #1;
    check("bp_first_rdy0", 64'(req0_ready), 64'd1);
    step();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp%0d_rdy0", i), 64'(req0_ready), 64'd0);
      check($sformatf("bp%0d_rdy1", i), 64'(req1_ready), 64'd0);
      check($sformatf("bp%0d_valid", i), 64'(rsp_valid), 64'd1);
      check($sformatf("bp%0d_id", i), 64'(rsp_id), 64'd0);
      check($sformatf("bp%0d_result", i), rsp_result, 64'd0);
      check($sformatf("bp%0d_cc", i), 64'(rsp_cc), 64'd4);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_rel_rdy1", 64'(req1_ready), 64'd1);
    check("bp_rel_rdy0", 64'(req0_ready), 64'd0);
    step();
    check("bp_rel_valid", 64'(rsp_valid), 64'd1);
    check("bp_rel_id", 64'(rsp_id), 64'd1);
    check("bp_rel_result", rsp_result, 64'hFF);

    // serve req0 alone so a tie would favour req1, then stall and reset
    req1_valid = 1'b0;
    step();
    check("pre_rst_id", 64'(rsp_id), 64'd0);
    req0_valid = 1'b0; rsp_ready = 1'b0;
    step();
    check("pre_rst_valid", 64'(rsp_valid), 64'd1);
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    check("in_rst_rdy0", 64'(req0_ready), 64'd0);
    check("in_rst_rdy1", 64'(req1_ready), 64'd0);
    step();
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    check("post_rst_valid", 64'(rsp_valid), 64'd0);
    check("post_rst_id", 64'(rsp_id), 64'd0);
    check("post_rst_result", rsp_result, 64'd0);
    check("post_rst_cc", 64'(rsp_cc), 64'd0);
    step();
    check("post_rst_valid2", 64'(rsp_valid), 64'd0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("post_rst_tie_rdy0", 64'(req0_ready), 64'd1);
    check("post_rst_tie_rdy1", 64'(req1_ready), 64'd0);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("post_rst_tie_id", 64'(rsp_id), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
